// File: rtl/farbfeld_fb_writer_pkg.sv
// Shared types and helpers for the farbfeld framebuffer writer.
package farbfeld_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // 16-bit-per-channel colour reduced to RGB565 by keeping the top bits.
    function automatic logic [15:0] rgb565(input logic [15:0] r,
                                           input logic [15:0] g,
                                           input logic [15:0] b);
        return {r[15:11], g[15:10], b[15:11]};
    endfunction

endpackage

// File: rtl/farbfeld_fb_writer_if.sv
// Valid/ack framebuffer memory write port.
interface farbfeld_fb_writer_if #(
    parameter int ADDR_W = 19
);
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_data;
    logic              fb_ack;

    modport master (output fb_we, fb_addr, fb_data, input fb_ack);
    modport slave  (input fb_we, fb_addr, fb_data, output fb_ack);
endinterface

// File: rtl/farbfeld_fb_writer_fifo.sv
// Synchronous FIFO holding pending framebuffer writes; head is read combinationally.
module fb_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // NOTE: storage has no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/farbfeld_fb_writer.sv
// Captures parsed farbfeld pixels, converts to RGB565 and writes them to a
// framebuffer through a small queue and a valid/ack port.
module farbfeld_fb_writer
    import farbfeld_pkg::*;
#(
    parameter int FB_WIDTH    = 640,
    parameter int FB_HEIGHT   = 480,
    parameter int ADDR_W      = 19,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pixelready,
    input  logic [31:0]          row,
    input  logic [31:0]          col,
    input  logic [15:0]          red,
    input  logic [15:0]          green,
    input  logic [15:0]          blue,
    farbfeld_fb_writer_if.master fb,
    output logic                 overflow,
    output logic                 frame_done,
    output logic [31:0]          pixels_written
);

    localparam int ENTRY_W = ADDR_W + 16;
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   cap_q;

    logic              s1_valid;
    logic              s1_clip;
    logic [ADDR_W-1:0] s1_addr;
    logic [15:0]       s1_data;

    logic              push_req;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [15:0]       head_data;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;

    state_t state;
    logic   we_q;

    // Capture fires on the registered rising edge of the synchronised level,
    // so a long pixelready high yields a single event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
            cap_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pixelready};
            sync_prev <= sync_q[SYNC_STAGES-1];
            cap_q     <= sync_q[SYNC_STAGES-1] & ~sync_prev;
        end
    end

    // Clip uses the full 32-bit coordinates; the address wraps to ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_clip  <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= cap_q;
            if (cap_q) begin
                s1_clip <= (row >= 32'(FB_HEIGHT)) || (col >= 32'(FB_WIDTH));
                s1_addr <= ADDR_W'(row) * ADDR_W'(FB_WIDTH) + ADDR_W'(col);
                s1_data <= rgb565(red, green, blue);
            end
        end
    end

    assign push_req = s1_valid & ~s1_clip;
    assign pop      = (state == ST_WRITE) & fb.fb_ack;
    assign push     = push_req & (~full | pop);

    fb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({s1_addr, s1_data}),
        .pop       (pop),
        .head      ({head_addr, head_data}),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push_req && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // The head entry stays in the queue until acked, so a full queue with a
    // stalled write holds exactly FIFO_DEPTH pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            we_q           <= 1'b0;
            frame_done     <= 1'b0;
            pixels_written <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state <= ST_WRITE;
                        we_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (fb.fb_ack) begin
                        pixels_written <= pixels_written + 32'd1;
                        frame_done     <= (head_addr == LAST_ADDR);
                        if ((level <= LVL_W'(1)) && !push) begin
                            state <= ST_IDLE;
                            we_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fb.fb_we   = we_q;
    assign fb.fb_addr = we_q ? head_addr : '0;
    assign fb.fb_data = we_q ? head_data : '0;

endmodule
